// File: rtl/lu_sweep_ctrl_if.sv
// Signal bundle between the sweep controller, its requester and the logic unit.
// The master side is the controller; the slave side is the requester / logic unit.
interface lu_sweep_ctrl_if;
  logic        start;
  logic        r_in;
  logic        x;
  logic        y;
  logic [0:2]  key;
  logic        busy;
  logic        done;
  logic [31:0] truth_table;
  logic        mismatch;
  logic [5:0]  err_cnt;

  modport master (
    input  start, r_in,
    output x, y, key, busy, done, truth_table, mismatch, err_cnt
  );

  modport slave (
    output start, r_in,
    input  x, y, key, busy, done, truth_table, mismatch, err_cnt
  );
endinterface

// File: rtl/lu_sweep_ctrl.sv
// Sweeps every {key,x,y} vector of the selectable logic unit and packs the sampled results
// into a 32-bit truth table. Define LU_CHECK_EN to build the golden-model compare logic.
module lu_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned KEY_LO = 0,
  parameter int unsigned KEY_HI = 7
) (
  input  logic            clk,
  input  logic            rst,
  lu_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [4:0] V_FIRST  = 5'(KEY_LO * 4);
  localparam logic [4:0] V_LAST   = 5'(KEY_HI * 4 + 3);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  v;
  logic [3:0]  cnt;
  logic [31:0] tbl;
  logic        load_first;
  logic        sample_en;
  logic        last_vec;

  assign last_vec = (v == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    sample_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load_first = 1'b1;
          state_nxt  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == 4'd0) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        state_nxt = last_vec ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands only move on the start-accept edge or the edge leaving SAMPLE, so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      cnt <= '0;
      tbl <= '0;
    end else if (load_first) begin
      v   <= V_FIRST;
      cnt <= CNT_INIT;
      tbl <= '0;
    end else if (state == ST_SETTLE && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else if (sample_en) begin
      tbl[v] <= bus.r_in;
      if (!last_vec) begin
        v   <= v + 5'd1;
        cnt <= CNT_INIT;
      end
    end
  end

  assign bus.key         = v[4:2];
  assign bus.x           = v[1];
  assign bus.y           = v[0];
  assign bus.busy        = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign bus.done        = (state == ST_DONE);
  assign bus.truth_table = tbl;

`ifdef LU_CHECK_EN
  // Expected nibbles per key, indexed by {key,x,y} exactly like the truth table.
  localparam logic [31:0] GOLDEN = 32'h961E7853;

  logic       mismatch_q;
  logic [5:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else if (load_first) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else if (sample_en && (bus.r_in != GOLDEN[v])) begin
      mismatch_q <= 1'b1;
      if (err_q != 6'd63) err_q <= err_q + 6'd1;
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_q;
`else
  assign bus.mismatch = 1'b0;
  assign bus.err_cnt  = '0;
`endif

endmodule

// File: doc/lu_sweep_ctrl.md
Name: lu_sweep_ctrl

Overview:
- Upstream driver and result collector for the 3-bit-key selectable two-input logic unit (key 0..7 = NOT x, NOT y, AND, NAND, OR, NOR, XOR, XNOR).
- On `start`, the block sweeps every (key, x, y) vector in the configured key range and drives the unit's x, y and key inputs.
- It waits a programmable settle time, samples the unit's result `r`, and packs the results into a 32-bit truth-table register.
- Used for self-test and bring-up of the logic unit.

Parameters:
- SETTLE, 1, cycles that operands are held stable before `r_in` is sampled; legal range 1..15.
- KEY_LO, 0, first key value swept; legal range 0..7.
- KEY_HI, 7, last key value swept; legal range KEY_LO..7.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- r_in  input  1  result from the logic unit (combinational from x, y, key).
- x  output  1  operand x to the logic unit, registered.
- y  output  1  operand y to the logic unit, registered.
- key  output  [0:2]  operation select to the unit; key[0] is the MSB, so value 3'b001 selects NOT y.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table  output  32  captured results; bit index = key*4 + x*2 + y.
- mismatch  output  1  sticky compare-error flag (see Optional Feature).
- err_cnt  output  6  count of compare errors (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-sweep):
  - state=IDLE.
  - x=0, y=0, key=0, busy=0, done=0, table=0, mismatch=0, err_cnt=0.
  - Internal vector index v=0, settle counter=0.
- Vector index v is 5 bits = {key, x, y}; the outputs x, y, key are always the registered fields of v.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0, done=0.
  - When start=1: v <= KEY_LO*4, table <= 0, mismatch <= 0, err_cnt <= 0, counter <= SETTLE-1, go to SETTLE.
  - When start=0: outputs hold their last values.
- SETTLE:
  - busy=1.
  - If counter==0, go to SAMPLE; otherwise counter decrements by 1.
  - This holds the operands stable for exactly SETTLE cycles.
- SAMPLE (busy=1):
  - table[v] <= r_in.
  - If v == KEY_HI*4+3, go to DONE.
  - Otherwise v <= v+1, counter <= SETTLE-1, go to SETTLE.
  - The new operands appear on x, y, key in the cycle after SAMPLE.
- DONE:
  - done=1 for exactly one cycle, busy=0, go to IDLE.
  - x, y, key hold the last vector.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - A sweep of N keys takes 4*N*(SETTLE+1) cycles from the start-accept edge to DONE entry.
  - done asserts on the following cycle.
- start while busy, or during the DONE cycle, is ignored; there is no queuing.
- Table bits for keys outside KEY_LO..KEY_HI are always 0.
- table is stable and readable from the DONE cycle until the next accepted start.
- x, y, key never glitch: they change only on the edge leaving SAMPLE or on the start-accept edge.
- v increments within the range only; there is no wrap past KEY_HI*4+3.

Optional Feature:
- Macro: LU_CHECK_EN.
- Enabled:
  - An internal golden model computes the expected result per vector. Key 0..7 expected nibbles (indexed by x*2+y) are 0x3, 0x5, 0x8, 0x7, 0xE, 0x1, 0x6, 0x9.
  - In SAMPLE, if r_in differs from the expected bit: mismatch <= 1 (sticky until the next accepted start or rst), and err_cnt <= err_cnt+1, saturating at 63.
- Disabled: mismatch and err_cnt ports are still present and tied to 0; no compare logic is built.

Test Plan:
- Defaults, r_in driven by an ideal logic-unit model, start pulsed in cycle 0 → busy for 64 cycles; done pulses once; table=0x961E7853; mismatch=0, err_cnt=0.
- Defaults, r_in tied 0, LU_CHECK_EN defined → table=0x00000000; mismatch=1; err_cnt=16 at done.
- KEY_LO=2, KEY_HI=3, SETTLE=3, ideal model → key is first driven to 2 with x=0, y=0; the sweep takes 32 cycles; table=0x00007800.
- start re-pulsed at cycles 5 and 40 of a default sweep → ignored; exactly one done pulse, at the same cycle as in the first scenario; table unchanged from 0x961E7853.
- rst asserted for 1 cycle at cycle 20 of a sweep → on the next cycle: state IDLE, busy=0, table=0, x=y=key=0; no done pulse. A new start then completes a normal sweep.
- SETTLE=1, check that r_in sampling aligns: a model that inverts r_in only while x/y changed in the previous cycle → every sampled bit is still correct (table=0x961E7853), proving at least one full stable cycle before each sample.
